tl_ul_initiator: RTL and testbench

- TileLink-UL master (initiator) that converts a simple valid/ready command port into channel-A Get / PutFullData / PutPartialData requests.
- Collects channel-D AccessAck / AccessAckData responses and returns them on a valid/ready response port.
- Up to MAX_OUTSTANDING transactions may be in flight, each tagged with a unique a_source.
- Used by bus masters such as a debug port or DMA front-end to drive slaves like the interrupt controller and the timers.

---
 rtl/tl_ul_initiator.sv | 180 ++++++++++++++++++
 tb/tb_tl_ul_initiator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_initiator.sv
// TileLink-UL initiator: command port to channel A, channel D to response port.
// Optional response checking is built when TL_UL_INITIATOR_PROTO_CHECK_EN is defined.
module tl_ul_initiator #(
  parameter int TL_RS           = 4,
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              tlm_clock_i,
  input  logic              tlm_reset_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [1:0]        cmd_size,
  input  logic [3:0]        cmd_mask,
  input  logic [31:0]       cmd_data,
  output logic [2:0]        tl_a_opcode,
  output logic [2:0]        tl_a_param,
  output logic [3:0]        tl_a_size,
  output logic [TL_RS-1:0]  tl_a_source,
  output logic [ADDR_W-1:0] tl_a_address,
  output logic [3:0]        tl_a_mask,
  output logic [31:0]       tl_a_data,
  output logic              tl_a_corrupt,
  output logic              tl_a_valid,
  input  logic              tl_a_ready,
  input  logic [2:0]        tl_d_opcode,
  input  logic [1:0]        tl_d_param,
  input  logic [3:0]        tl_d_size,
  input  logic [TL_RS-1:0]  tl_d_source,
  input  logic              tl_d_denied,
  input  logic [31:0]       tl_d_data,
  input  logic              tl_d_corrupt,
  input  logic              tl_d_valid,
  output logic              tl_d_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_error,
  output logic [TL_RS-1:0]  rsp_tag,
  output logic              busy_o,
  output logic              proto_err_o
);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  logic [MAX_OUTSTANDING-1:0] inflight_q;
  logic [MAX_OUTSTANDING-1:0] inflight_d;
  logic [TL_RS-1:0]           free_id;
  logic                       free_avail;
  logic [3:0]                 lane_mask;
  logic                       cmd_fire;
  logic                       a_fire;
  logic                       d_fire;
  logic                       unused_d;

  assign unused_d = ^{tl_d_size, tl_d_param};

  always_comb begin
    lane_mask = 4'hF;
    unique case (cmd_size)
      2'd0:    lane_mask = 4'b0001 << cmd_address[1:0];
      2'd1:    lane_mask = cmd_address[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'hF;
    endcase
  end

  // Scan downward so the lowest clear bit wins.
  always_comb begin
    free_avail = 1'b0;
    free_id    = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!inflight_q[i]) begin
        free_avail = 1'b1;
        free_id    = TL_RS'(i);
      end
    end
  end

  assign cmd_ready = (!tl_a_valid || tl_a_ready) && free_avail;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign a_fire    = tl_a_valid && tl_a_ready;
  assign tl_d_ready = !rsp_valid || rsp_ready;
  assign d_fire    = tl_d_valid && tl_d_ready;

  always_comb begin
    inflight_d = inflight_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (d_fire && tl_d_source == TL_RS'(i))
        inflight_d[i] = 1'b0;
      if (cmd_fire && free_id == TL_RS'(i))
        inflight_d[i] = 1'b1;
    end
  end

  always_ff @(posedge tlm_clock_i or posedge tlm_reset_i) begin
    if (tlm_reset_i) begin
      inflight_q <= '0;
      tl_a_valid <= 1'b0;
      rsp_valid  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (cmd_fire)
        tl_a_valid <= 1'b1;
      else if (a_fire)
        tl_a_valid <= 1'b0;
      if (d_fire)
        rsp_valid <= 1'b1;
      else if (rsp_ready)
        rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge tlm_clock_i) begin
    if (cmd_fire) begin
      if (!cmd_write)
        tl_a_opcode <= OP_GET;
      else if (cmd_mask == lane_mask)
        tl_a_opcode <= OP_PUT_FULL;
      else
        tl_a_opcode <= OP_PUT_PART;
      tl_a_mask    <= cmd_write ? (cmd_mask & lane_mask) : lane_mask;
      tl_a_size    <= {2'b00, cmd_size};
      tl_a_source  <= free_id;
      tl_a_address <= cmd_address;
      tl_a_data    <= cmd_data;
    end
    if (d_fire) begin
      rsp_data  <= (tl_d_opcode == OP_ACK_DATA) ? tl_d_data : 32'h0;
      rsp_error <= tl_d_denied | tl_d_corrupt;
      rsp_tag   <= tl_d_source;
    end
  end

  assign tl_a_param   = 3'd0;
  assign tl_a_corrupt = 1'b0;
  assign busy_o       = (|inflight_q) || tl_a_valid;

`ifdef TL_UL_INITIATOR_PROTO_CHECK_EN
  logic [MAX_OUTSTANDING-1:0] is_get_q;
  logic                       d_known;
  logic                       d_get;
  logic                       d_bad;

  always_comb begin
    d_known = 1'b0;
    d_get   = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (tl_d_source == TL_RS'(i)) begin
        d_known = inflight_q[i];
        d_get   = is_get_q[i];
      end
    end
  end

  assign d_bad = !d_known || (tl_d_param != 2'd0) ||
                 (tl_d_opcode != (d_get ? OP_ACK_DATA : OP_ACK));

  always_ff @(posedge tlm_clock_i or posedge tlm_reset_i) begin
    if (tlm_reset_i) begin
      is_get_q    <= '0;
      proto_err_o <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (cmd_fire && free_id == TL_RS'(i))
          is_get_q[i] <= !cmd_write;
      end
      if (d_fire && d_bad)
        proto_err_o <= 1'b1;
    end
  end
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tl_ul_initiator.sv
// Directed plus randomized bench for tl_ul_initiator.
// Reference model tracks in-flight IDs and expected A/response fields.
module tb_tl_ul_initiator;
  localparam int TL_RS  = 4;
  localparam int ADDR_W = 32;
  localparam int MAXO   = 4;
`ifdef TL_UL_INITIATOR_PROTO_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [1:0]        cmd_size;
  logic [3:0]        cmd_mask;
  logic [31:0]       cmd_data;
  logic [2:0]        tl_a_opcode, tl_a_param;
  logic [3:0]        tl_a_size;
  logic [TL_RS-1:0]  tl_a_source;
  logic [ADDR_W-1:0] tl_a_address;
  logic [3:0]        tl_a_mask;
  logic [31:0]       tl_a_data;
  logic              tl_a_corrupt, tl_a_valid, tl_a_ready;
  logic [2:0]        tl_d_opcode;
  logic [1:0]        tl_d_param;
  logic [3:0]        tl_d_size;
  logic [TL_RS-1:0]  tl_d_source;
  logic              tl_d_denied;
  logic [31:0]       tl_d_data;
  logic              tl_d_corrupt, tl_d_valid, tl_d_ready;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_error;
  logic [TL_RS-1:0]  rsp_tag;
  logic              busy_o, proto_err_o;

  int tests = 0;
  int fails = 0;
  bit infl[16];
  bit getrec[16];

  always #5 clk = ~clk;

  tl_ul_initiator #(.TL_RS(TL_RS), .ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAXO)) dut (
    .tlm_clock_i(clk), .tlm_reset_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_size(cmd_size), .cmd_mask(cmd_mask),
    .cmd_data(cmd_data),
    .tl_a_opcode(tl_a_opcode), .tl_a_param(tl_a_param), .tl_a_size(tl_a_size),
    .tl_a_source(tl_a_source), .tl_a_address(tl_a_address),
    .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data), .tl_a_corrupt(tl_a_corrupt),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready),
    .tl_d_opcode(tl_d_opcode), .tl_d_param(tl_d_param), .tl_d_size(tl_d_size),
    .tl_d_source(tl_d_source), .tl_d_denied(tl_d_denied), .tl_d_data(tl_d_data),
    .tl_d_corrupt(tl_d_corrupt), .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_tag(rsp_tag),
    .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [31:0] a);
    int bytes;
    bytes = 1 << sz;
    return 4'(((1 << bytes) - 1) << (a % 4));
  endfunction

  function automatic int exp_src();
    for (int i = 0; i < MAXO; i++)
      if (!infl[i]) return i;
    return -1;
  endfunction

  function automatic int n_infl();
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(infl[i]);
    return n;
  endfunction

  task automatic issue(input bit w, input logic [31:0] a, input logic [1:0] sz,
                       input logic [3:0] m, input logic [31:0] d);
    int n;
    int src;
    logic [3:0] l;
    cmd_write = w; cmd_address = a; cmd_size = sz; cmd_mask = m; cmd_data = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    src = exp_src();
    l = lanes(sz, a);
    tick();
    cmd_valid = 1'b0;
    chk("a_valid", 32'(tl_a_valid), 32'd1);
    chk("a_opcode", 32'(tl_a_opcode), !w ? 32'd4 : (m == l ? 32'd0 : 32'd1));
    chk("a_mask", 32'(tl_a_mask), w ? 32'(m & l) : 32'(l));
    chk("a_source", 32'(tl_a_source), 32'(src));
    chk("a_address", tl_a_address, a);
    chk("a_size", 32'(tl_a_size), 32'(sz));
    chk("a_data", tl_a_data, d);
    chk("a_param_corrupt", 32'({tl_a_param, tl_a_corrupt}), 32'd0);
    if (src >= 0) begin
      infl[src] = 1'b1;
      getrec[src] = !w;
    end
  endtask

  task automatic respond(input int src, input logic [2:0] op, input logic [31:0] d,
                         input bit den, input bit cor);
    int n;
    tl_d_source = TL_RS'(src); tl_d_opcode = op; tl_d_data = d;
    tl_d_denied = den; tl_d_corrupt = cor; tl_d_param = 2'd0; tl_d_size = 4'd2;
    tl_d_valid = 1'b1;
    n = 0;
    while (!tl_d_ready && n < 20) begin
      tick();
      n++;
    end
    chk("d_ready", 32'(tl_d_ready), 32'd1);
    tick();
    tl_d_valid = 1'b0;
    infl[src] = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", rsp_data, (op == 3'd1) ? d : 32'd0);
    chk("rsp_error", 32'(rsp_error), 32'(den | cor));
    chk("rsp_tag", 32'(rsp_tag), 32'(src));
    chk("busy_after_d", 32'(busy_o), 32'(n_infl() != 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    logic [3:0]  m;
    bit          w;
    int          k;
    int          s;
    cmd_valid = 0; cmd_write = 0; cmd_address = 0; cmd_size = 0;
    cmd_mask = 0; cmd_data = 0; tl_a_ready = 1;
    tl_d_opcode = 0; tl_d_param = 0; tl_d_size = 0; tl_d_source = 0;
    tl_d_denied = 0; tl_d_data = 0; tl_d_corrupt = 0; tl_d_valid = 0;
    rsp_ready = 1;
    for (int i = 0; i < 16; i++) begin infl[i] = 0; getrec[i] = 0; end

    repeat (2) tick();
    chk("rst_a_valid", 32'(tl_a_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_proto_err", 32'(proto_err_o), 32'd0);
    rst = 0;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Read word
    issue(1'b0, 32'h1000, 2'd2, 4'h0, 32'h0);
    respond(0, 3'd1, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    chk("rsp_drop", 32'(rsp_valid), 32'd0);

    // Byte write then partial write; write acks return zero data
    issue(1'b1, 32'h1003, 2'd0, 4'h8, 32'hAABBCCDD);
    respond(0, 3'd0, 32'h12345678, 1'b0, 1'b0);
    issue(1'b1, 32'h1000, 2'd2, 4'h3, 32'h01020304);
    respond(0, 3'd0, 32'h9, 1'b0, 1'b0);

    // Channel-A backpressure
    tl_a_ready = 0;
    issue(1'b0, 32'h2004, 2'd2, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_a_valid", 32'(tl_a_valid), 32'd1);
      chk("bp_opcode", 32'(tl_a_opcode), 32'd4);
      chk("bp_address", tl_a_address, 32'h2004);
      chk("bp_source", 32'(tl_a_source), 32'd0);
      chk("bp_mask", 32'(tl_a_mask), 32'hF);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    tl_a_ready = 1;
    tick();
    chk("bp_a_drained", 32'(tl_a_valid), 32'd0);
    respond(0, 3'd1, 32'h5555AAAA, 1'b0, 1'b0);

    // Outstanding limit
    for (int i = 0; i < MAXO; i++)
      issue(1'b0, 32'h3000 + 32'(4 * i), 2'd2, 4'h0, 32'h0);
    tick();
    cmd_write = 0; cmd_address = 32'h3010; cmd_size = 2; cmd_valid = 1;
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("full_cmd_ready2", 32'(cmd_ready), 32'd0);
    respond(2, 3'd1, 32'h22222222, 1'b0, 1'b0);
    chk("freed_cmd_ready", 32'(cmd_ready), 32'd1);
    issue(1'b0, 32'h3010, 2'd2, 4'h0, 32'h0);

    // Out-of-order completion with error
    respond(1, 3'd1, 32'h11111111, 1'b1, 1'b0);
    respond(0, 3'd1, 32'h00000000, 1'b0, 1'b0);
    respond(3, 3'd1, 32'h33333333, 1'b0, 1'b1);
    chk("busy_before_last", 32'(busy_o), 32'd1);
    respond(2, 3'd1, 32'h44444444, 1'b0, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      if (n_infl() < MAXO && (n_infl() == 0 || $urandom_range(0, 1) == 1)) begin
        sz = 2'($urandom_range(0, 2));
        a = ($urandom >> sz) << sz;
        w = 1'($urandom_range(0, 1));
        m = ($urandom_range(0, 1) == 1) ? lanes(sz, a) : 4'($urandom);
        issue(w, a, sz, m, $urandom);
      end else begin
        k = $urandom_range(0, n_infl() - 1);
        s = -1;
        for (int i = 0; i < MAXO; i++) begin
          if (infl[i]) begin
            if (k == 0 && s < 0) s = i;
            k--;
          end
        end
        respond(s, getrec[s] ? 3'd1 : 3'd0, $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
    end
    tick();
    while (n_infl() != 0) begin
      for (int i = 0; i < MAXO; i++)
        if (infl[i]) respond(i, getrec[i] ? 3'd1 : 3'd0, $urandom, 1'b0, 1'b0);
    end
    chk("rand_idle_busy", 32'(busy_o), 32'd0);

    // Response on an idle source
    respond(3, 3'd0, 32'h0, 1'b0, 1'b0);
    chk("proto_err_set", 32'(proto_err_o), 32'(PCHK));
    repeat (3) tick();
    chk("proto_err_sticky", 32'(proto_err_o), 32'(PCHK));

    // Reset with a request pending
    tl_a_ready = 0;
    issue(1'b0, 32'h4000, 2'd2, 4'h0, 32'h0);
    rst = 1;
    #1;
    chk("mid_rst_a_valid", 32'(tl_a_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_proto_err", 32'(proto_err_o), 32'd0);
    for (int i = 0; i < 16; i++) infl[i] = 0;
    tick();
    rst = 0;
    tl_a_ready = 1;
    tick();
    issue(1'b0, 32'h4008, 2'd2, 4'h0, 32'h0);
    respond(0, 3'd1, 32'hCAFEF00D, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
